// File: rtl/cc_attach_debounce_pkg.sv
// Shared types and helpers for the Type-C CC attach/detach debounce front end.
// State encodings are one-hot so a corrupted register is easy to detect.
package cc_attach_debounce_pkg;

    typedef enum logic [3:0] {
        ST_UNATTACHED  = 4'b0001,
        ST_ATTACH_WAIT = 4'b0010,
        ST_ATTACHED    = 4'b0100,
        ST_DETACH_WAIT = 4'b1000
    } cc_state_e;

    localparam logic ORIENT_CC1 = 1'b0;
    localparam logic ORIENT_CC2 = 1'b1;

    // A valid attach candidate is exactly one CC line high.
    function automatic logic isCandidate(input logic s1, input logic s2);
        return s1 ^ s2;
    endfunction

    function automatic logic selectedLevel(input logic sel, input logic s1, input logic s2);
        return (sel == ORIENT_CC2) ? s2 : s1;
    endfunction

endpackage

// File: rtl/cc_sync2.sv
// Two-flop synchroniser for one asynchronous comparator level, cleared by reset.
module cc_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cc_attach_debounce.sv
// CC1/CC2 attach front end: synchronises raw comparator levels, debounces attach and
// detach, resolves orientation and presents a single clean attach line to the driver FSM.
module cc_attach_debounce
    import cc_attach_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DETACH_CYCLES   = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cc1_raw,
    input  logic cc2_raw,
    output logic CC1,
    output logic CC2,
    output logic attached,
    output logic orientation,
    output logic attach_event
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DET_LAST = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic s1;
    logic s2;

    cc_sync2 u_sync_cc1 (
        .clk   (clk),
        .reset (reset),
        .d_i   (cc1_raw),
        .q_o   (s1)
    );

    cc_sync2 u_sync_cc2 (
        .clk   (clk),
        .reset (reset),
        .d_i   (cc2_raw),
        .q_o   (s2)
    );

    cc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;

    logic             attached_q, attached_d;
    logic             orient_q, orient_d;
    logic             cc1_q, cc1_d;
    logic             cc2_q, cc2_d;
    logic             event_q, event_d;

    logic             cand;
    logic             match;
    logic             selHigh;
    logic [CNT_W-1:0] cntInc;

    assign cand    = isCandidate(s1, s2);
    assign match   = cand && (s2 == sel_q);
    assign selHigh = selectedLevel(sel_q, s1, s2);
    assign cntInc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Any pattern change during ATTACH_WAIT forces a full restart from UNATTACHED.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            ST_UNATTACHED: begin
                cnt_d = '0;
                if (cand) begin
                    state_d = ST_ATTACH_WAIT;
                    sel_d   = s2;
                end
            end
            ST_ATTACH_WAIT: begin
                if (!match) begin
                    state_d = ST_UNATTACHED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_ATTACHED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cntInc;
                end
            end
            ST_ATTACHED: begin
                cnt_d = '0;
                if (!selHigh) begin
                    state_d = ST_DETACH_WAIT;
                end
            end
            ST_DETACH_WAIT: begin
                if (selHigh) begin
                    state_d = ST_ATTACHED;
                    cnt_d   = '0;
                end else if (cnt_q == DET_LAST) begin
                    state_d = ST_UNATTACHED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cntInc;
                end
            end
            default: begin
                state_d = ST_UNATTACHED;
                cnt_d   = '0;
                sel_d   = ORIENT_CC1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_UNATTACHED;
            cnt_q   <= '0;
            sel_q   <= ORIENT_CC1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Outputs are derived from the next state so they change on the same edge as it.
    always_comb begin
        attached_d = (state_d == ST_ATTACHED) || (state_d == ST_DETACH_WAIT);
        orient_d   = attached_d ? sel_d : ORIENT_CC1;
        cc1_d      = attached_d & ~orient_d;
        cc2_d      = attached_d & orient_d;
        event_d    = (state_q == ST_ATTACH_WAIT) && (state_d == ST_ATTACHED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            attached_q <= 1'b0;
            orient_q   <= ORIENT_CC1;
            cc1_q      <= 1'b0;
            cc2_q      <= 1'b0;
            event_q    <= 1'b0;
        end else begin
            attached_q <= attached_d;
            orient_q   <= orient_d;
            cc1_q      <= cc1_d;
            cc2_q      <= cc2_d;
            event_q    <= event_d;
        end
    end

    assign CC1          = cc1_q;
    assign CC2          = cc2_q;
    assign attached     = attached_q;
    assign orientation  = orient_q;
    assign attach_event = event_q;

endmodule

// File: tb/tb_cc_attach_debounce.sv
// Directed self-checking bench for cc_attach_debounce at default parameters.
// Expected output vectors are {CC1, CC2, attached, orientation, attach_event}.
module tb_cc_attach_debounce;

    logic clk = 1'b0;
    logic reset;
    logic cc1_raw;
    logic cc2_raw;
    logic CC1;
    logic CC2;
    logic attached;
    logic orientation;
    logic attach_event;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    localparam logic [4:0] IDLE    = 5'b00000;
    localparam logic [4:0] A1_EVT  = 5'b10101;
    localparam logic [4:0] A1_HOLD = 5'b10100;
    localparam logic [4:0] A2_EVT  = 5'b01111;
    localparam logic [4:0] A2_HOLD = 5'b01110;

    cc_attach_debounce dut (
        .clk          (clk),
        .reset        (reset),
        .cc1_raw      (cc1_raw),
        .cc2_raw      (cc2_raw),
        .CC1          (CC1),
        .CC2          (CC2),
        .attached     (attached),
        .orientation  (orientation),
        .attach_event (attach_event)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic c1, input logic c2);
        cc1_raw = c1;
        cc2_raw = c2;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        observed = {CC1, CC2, attached, orientation, attach_event};
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Step one edge at a time, checking the same vector after each.
    task automatic checkHold(input string tag, input int n, input logic [4:0] expected);
        for (int i = 0; i < n; i++) begin
            stepCycles(1);
            checkOutput(tag, expected);
        end
    endtask

    initial begin
        // Reset held three cycles with CC1 asserted.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkHold("reset_hold", 3, IDLE);
        reset = 1'b0;

        // Steady CC1 attach: edges 0..17 idle, attach on edge 18, event only once.
        checkHold("cc1_debounce", 18, IDLE);
        stepCycles(1);
        checkOutput("cc1_attach_edge18", A1_EVT);
        checkHold("cc1_attached_hold", 3, A1_HOLD);

        // Short dropout on CC1 is filtered.
        applyStimulus(1'b0, 1'b0);
        checkHold("cc1_glitch_low", 3, A1_HOLD);
        applyStimulus(1'b1, 1'b0);
        checkHold("cc1_glitch_recover", 10, A1_HOLD);

        // Sustained CC1 low detaches on edge 6.
        applyStimulus(1'b0, 1'b0);
        checkHold("cc1_detach_wait", 6, A1_HOLD);
        stepCycles(1);
        checkOutput("cc1_detach_edge6", IDLE);
        checkHold("cc1_detached", 4, IDLE);

        // CC2 pulse too short to attach, then a full CC2 attach.
        applyStimulus(1'b0, 1'b1);
        checkHold("cc2_short_run", 10, IDLE);
        applyStimulus(1'b0, 1'b0);
        checkHold("cc2_short_gap", 5, IDLE);
        applyStimulus(1'b0, 1'b1);
        checkHold("cc2_debounce", 18, IDLE);
        stepCycles(1);
        checkOutput("cc2_attach_edge18", A2_EVT);
        checkHold("cc2_attached_hold", 1, A2_HOLD);
        applyStimulus(1'b0, 1'b0);
        checkHold("cc2_detach_wait", 6, A2_HOLD);
        stepCycles(1);
        checkOutput("cc2_detach_edge6", IDLE);

        // Both lines high from reset never attaches.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1);
        checkHold("both_reset", 2, IDLE);
        reset = 1'b0;
        checkHold("both_high", 40, IDLE);

        // Attach on CC1, then assert CC2 as well: attachment on CC1 must hold.
        applyStimulus(1'b1, 1'b0);
        checkHold("cc1_reattach_wait", 18, IDLE);
        stepCycles(1);
        checkOutput("cc1_reattach_edge18", A1_EVT);
        applyStimulus(1'b1, 1'b1);
        checkHold("cc2_ignored_when_attached", 10, A1_HOLD);

        // Reset mid-debounce at cnt=8, then attach completes 18 edges after release.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkHold("abort_setup_reset", 2, IDLE);
        reset = 1'b0;
        checkHold("abort_setup_idle", 3, IDLE);
        applyStimulus(1'b1, 1'b0);
        checkHold("abort_debounce", 11, IDLE);
        reset = 1'b1;
        checkHold("abort_reset_pulse", 1, IDLE);
        reset = 1'b0;
        checkHold("abort_restart", 18, IDLE);
        stepCycles(1);
        checkOutput("abort_attach_edge18", A1_EVT);
        checkHold("abort_attached_hold", 2, A1_HOLD);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
